// File: rtl/store_unit.sv
// store_unit: RISC-V SB/SH/SW store engine for a data BRAM.
// Full-word stores are written straight through. Byte and halfword stores do
// a read-modify-write of the containing word. Misaligned or unsupported
// requests end in a one-cycle error pulse and never touch the BRAM.
module store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [2:0]                req_func3,
  input  logic [31:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]     req_data,
  output logic                      req_ready,
  output logic                      stall,
  output logic [31:0]               mem_r_addr,
  output logic                      mem_r_enb,
  input  logic [DATA_WIDTH-1:0]     mem_r_dat,
  output logic [MEM_ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0]     mem_w_dat,
  output logic                      mem_w_enb,
  output logic                      done,
  output logic                      misaligned
);

  localparam logic [2:0] F_SB = 3'b000;
  localparam logic [2:0] F_SH = 3'b001;
  localparam logic [2:0] F_SW = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Request fields captured at the accept edge; the requester may change
  // its inputs afterwards.
  logic [31:0]           addr_q;
  logic [2:0]            func3_q;
  logic [DATA_WIDTH-1:0] data_q;
  // Word presented on the write port: raw store data for SW, merged word
  // for SB/SH.
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic accept;

  // True when the request cannot be performed: unknown width or bad alignment.
  function automatic logic req_is_bad(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      F_SB:    bad = 1'b0;
      F_SH:    bad = a[0];
      F_SW:    bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Overwrite the addressed little-endian byte/halfword lane of old_w.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [2:0]            f3,
    input logic [1:0]            a,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_w;
    if (f3 == F_SH) begin
      w[{a[1], 4'b0000} +: 16] = d[15:0];
    end else begin
      w[{a, 3'b000} +: 8] = d[7:0];
    end
    return w;
  endfunction

  assign accept = (state_q == IDLE) && req_valid;

  // State register; reset aborts any store in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: decode the request in IDLE, walk the RMW sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_is_bad(req_func3, req_addr[1:0])) begin
            state_d = ERR;
          end else if (req_func3 == F_SW) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = MERGE;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-word next value: store data on accept, merged word in MERGE.
  always_comb begin
    word_d = word_q;
    if (accept) begin
      word_d = req_data;
    end else if (state_q == MERGE) begin
      word_d = merge_lanes(mem_r_dat, func3_q, addr_q[1:0], data_q);
    end
  end

  // Datapath registers; they carry no reset because every output that
  // exposes them is gated by the state.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      func3_q <= req_func3;
      data_q  <= req_data;
    end
    word_q <= word_d;
  end

  // Outputs decoded from the current state only, plus the combinational stall.
  always_comb begin
    req_ready  = (state_q == IDLE);
    stall      = (state_q != IDLE) || req_valid;
    mem_r_enb  = 1'b0;
    mem_r_addr = '0;
    mem_w_enb  = 1'b0;
    mem_w_addr = '0;
    mem_w_dat  = '0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      READ: begin
        mem_r_enb  = 1'b1;
        mem_r_addr = {addr_q[31:2], 2'b00};
      end
      WRITE: begin
        mem_w_enb  = 1'b1;
        mem_w_addr = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
        mem_w_dat  = word_q;
        done       = 1'b1;
      end
      ERR: begin
        misaligned = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_ready;
  logic        stall;
  logic [31:0] mem_r_addr;
  logic        mem_r_enb;
  logic [31:0] mem_r_dat;
  logic [9:0]  mem_w_addr;
  logic [31:0] mem_w_dat;
  logic        mem_w_enb;
  logic        done;
  logic        misaligned;

  int tests = 0;
  int fails = 0;

  // BRAM environment model (sync read, one-cycle latency) with a preload port
  logic [31:0] bram [256];
  logic [31:0] rdat = 32'h0;
  logic        init_we;
  logic [7:0]  init_idx;
  logic [31:0] init_val;

  // Reference memory image: what the BRAM must hold after each store
  logic [31:0] ref_mem [256];

  store_unit #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_func3(req_func3),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .stall(stall), .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb),
    .mem_r_dat(mem_r_dat), .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat),
    .mem_w_enb(mem_w_enb), .done(done), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_we) bram[init_idx] <= init_val;
    else if (mem_w_enb) bram[mem_w_addr[9:2]] <= mem_w_dat;
    if (mem_r_enb) rdat <= bram[mem_r_addr[9:2]];
  end
  assign mem_r_dat = rdat;

  // Model: which requests are rejected
  function automatic bit model_err(input logic [2:0] f, input logic [31:0] a);
    int lo;
    lo = int'(a & 32'd3);
    if (f == 3'd0) return 1'b0;
    if (f == 3'd1) return (lo % 2) != 0;
    if (f == 3'd2) return lo != 0;
    return 1'b1;
  endfunction

  // Model: resulting memory word, built byte by byte
  function automatic logic [31:0] model_word(input logic [31:0] old, input logic [2:0] f,
                                             input logic [31:0] a, input logic [31:0] d);
    logic [7:0] b [4];
    int lo;
    if (f == 3'd2) return d;
    for (int k = 0; k < 4; k++) b[k] = 8'((old >> (8 * k)) & 32'hFF);
    lo = int'(a & 32'd3);
    b[lo] = 8'(d & 32'hFF);
    if (f == 3'd1) b[lo + 1] = 8'((d >> 8) & 32'hFF);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    init_we  = 1'b1;
    init_idx = 8'(idx);
    init_val = v;
    ref_mem[idx] = v;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  // One store transaction, entered one time unit after a rising edge in IDLE.
  // With hold set, the next request is presented right after acceptance and
  // kept valid while this one is in flight.
  task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, input logic [2:0] nf, input logic [31:0] na,
                          input logic [31:0] nd);
    bit          exp_err;
    int          exp_lat;
    int          idx;
    logic [31:0] exp_w;
    int          reads;
    bit          got;
    exp_err = model_err(f, a);
    exp_lat = (exp_err || f == 3'd2) ? 1 : 3;
    idx     = int'((a >> 2) & 32'hFF);
    exp_w   = model_word(ref_mem[idx], f, a, d);
    reads   = 0;
    got     = 1'b0;
    req_valid = 1'b1; req_func3 = f; req_addr = a; req_data = d;
    #1;
    tests++;
    if (req_ready !== 1'b1 || stall !== 1'b1) begin
      fails++;
      $display("FAIL accept_handshake: ready=%b stall=%b, expected ready=1 stall=1", req_ready, stall);
    end
    @(posedge clk); #1;
    if (hold) begin
      req_func3 = nf; req_addr = na; req_data = nd;
    end else begin
      req_valid = 1'b0; req_func3 = 3'($urandom); req_addr = $urandom; req_data = $urandom;
    end
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      tests++;
      if ((mem_r_enb && mem_w_enb) || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL busy_cycle: r_enb=%b w_enb=%b ready=%b, expected not both enables and ready=0",
                 mem_r_enb, mem_w_enb, req_ready);
      end
      if (mem_r_enb) begin
        reads++;
        tests++;
        if (mem_r_addr !== {a[31:2], 2'b00} || n != 2 - 1) begin
          fails++;
          $display("FAIL read_addr: addr=%h cycle=%0d, expected addr=%h cycle=1",
                   mem_r_addr, n, {a[31:2], 2'b00});
        end
      end
      if (mem_w_enb || misaligned) begin
        got = 1'b1;
        tests++;
        if (misaligned !== exp_err || mem_w_enb !== !exp_err || n != exp_lat) begin
          fails++;
          $display("FAIL outcome f=%0d a=%h: err=%b wr=%b cycle=%0d, expected err=%b cycle=%0d",
                   f, a, misaligned, mem_w_enb, n, exp_err, exp_lat);
        end
        tests++;
        if (exp_err) begin
          if (done !== 1'b0 || mem_r_enb !== 1'b0) begin
            fails++;
            $display("FAIL err_quiet: done=%b r_enb=%b, expected 0 0", done, mem_r_enb);
          end
        end else begin
          if (mem_w_addr !== (a[9:0] & 10'h3FC) || mem_w_dat !== exp_w || done !== 1'b1) begin
            fails++;
            $display("FAIL write f=%0d a=%h: addr=%h dat=%h done=%b, expected addr=%h dat=%h done=1",
                     f, a, mem_w_addr, mem_w_dat, done, a[9:0] & 10'h3FC, exp_w);
          end
          ref_mem[idx] = exp_w;
        end
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout f=%0d a=%h: no write or error pulse within 8 cycles", f, a);
    end
    tests++;
    if (reads != ((exp_err || f == 3'd2) ? 0 : 1)) begin
      fails++;
      $display("FAIL read_count f=%0d a=%h: reads=%0d, expected %0d", f, a, reads,
               (exp_err || f == 3'd2) ? 0 : 1);
    end
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || stall !== req_valid) begin
      fails++;
      $display("FAIL back_to_idle: ready=%b stall=%b, expected ready=1 stall=%b", req_ready, stall, req_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || mem_r_enb !== 1'b0 || mem_w_enb !== 1'b0 ||
        done !== 1'b0 || misaligned !== 1'b0 || mem_r_addr !== 32'h0 || mem_w_addr !== 10'h0 ||
        mem_w_dat !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b stall=%b ren=%b wen=%b done=%b mis=%b ra=%h wa=%h wd=%h, expected ready=1 rest 0",
               req_ready, stall, mem_r_enb, mem_w_enb, done, misaligned, mem_r_addr, mem_w_addr, mem_w_dat);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b stall=%b, expected 1 0", req_ready, stall);
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 256; i++) poke(i, $urandom);
  endtask

  task automatic test_directed();
    poke(2, 32'h0BAD_F00D);
    poke(1, 32'h1122_3344);
    poke(3, 32'h0000_0004);
    do_store(3'd2, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 3'd0, 32'h0, 32'h0);
    do_store(3'd0, 32'h0000_0005, 32'h0000_00AA, 1'b0, 3'd0, 32'h0, 32'h0);
    do_store(3'd1, 32'h0000_000E, 32'h0000_BEEF, 1'b0, 3'd0, 32'h0, 32'h0);
    tests++;
    if (bram[2] !== 32'hDEAD_BEEF || bram[1] !== 32'h1122_AA44 || bram[3] !== 32'hBEEF_0004) begin
      fails++;
      $display("FAIL directed_words: w8=%h w4=%h wC=%h, expected DEADBEEF 1122AA44 BEEF0004",
               bram[2], bram[1], bram[3]);
    end
  endtask

  task automatic test_misaligned();
    do_store(3'd2, 32'h0000_0006, 32'h1234_5678, 1'b0, 3'd0, 32'h0, 32'h0);
    do_store(3'd1, 32'h0000_0003, 32'h0000_5678, 1'b0, 3'd0, 32'h0, 32'h0);
    do_store(3'd4, 32'h0000_0010, 32'hCAFE_CAFE, 1'b0, 3'd0, 32'h0, 32'h0);
    do_store(3'd2, 32'h0000_0001, 32'hCAFE_CAFE, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    poke(0, 32'h0000_0000);
    do_store(3'd0, 32'h0000_0000, 32'h0000_0011, 1'b1, 3'd0, 32'h0000_0001, 32'h0000_0022);
    do_store(3'd0, 32'h0000_0001, 32'h0000_0022, 1'b0, 3'd0, 32'h0, 32'h0);
    tests++;
    if (bram[0] !== 32'h0000_2211) begin
      fails++;
      $display("FAIL back_to_back_word: got %h, expected 00002211", bram[0]);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f, nf;
    logic [31:0] a, na, d, nd;
    int          sel;
    bit          hold;
    sel = $urandom_range(0, 9);
    f = (sel < 3) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 9) ? 3'd2 : 3'($urandom_range(3, 7));
    a = $urandom; if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    d = $urandom;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      nf = (sel < 3) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      na = $urandom; if ($urandom_range(0, 1) == 1) na[1:0] = 2'b00;
      nd = $urandom;
      hold = ($urandom_range(0, 1) == 1) && (i != 79);
      do_store(f, a, d, hold, nf, na, nd);
      f = nf; a = na; d = nd;
    end
    req_valid = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (bram[i] !== ref_mem[i]) bad++;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL random_memory_image: %0d words differ, expected 0", bad);
      end
    end
  endtask

  task automatic test_reset_abort();
    poke(20, 32'hA5A5_5A5A);
    req_valid = 1'b1; req_func3 = 3'd0; req_addr = 32'h0000_0051; req_data = 32'h0000_00EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || mem_r_enb !== 1'b0 || mem_w_enb !== 1'b0 ||
        done !== 1'b0 || misaligned !== 1'b0 || mem_r_addr !== 32'h0 || mem_w_addr !== 10'h0 ||
        mem_w_dat !== 32'h0) begin
      fails++;
      $display("FAIL abort_outputs: ready=%b stall=%b ren=%b wen=%b done=%b mis=%b, expected ready=1 rest 0",
               req_ready, stall, mem_r_enb, mem_w_enb, done, misaligned);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      tests++;
      if (mem_w_enb !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_write: wen=%b done=%b, expected 0 0", mem_w_enb, done);
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (mem_w_enb !== 1'b0 || req_ready !== 1'b1) begin
        fails++;
        $display("FAIL abort_after_release: wen=%b ready=%b, expected 0 1", mem_w_enb, req_ready);
      end
    end
    tests++;
    if (bram[20] !== 32'hA5A5_5A5A) begin
      fails++;
      $display("FAIL abort_word: got %h, expected A5A55A5A", bram[20]);
    end
    @(posedge clk); #1;
    do_store(3'd0, 32'h0000_0052, 32'h0000_0077, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_func3 = 3'd0; req_addr = 32'h0; req_data = 32'h0;
    init_we = 1'b0; init_idx = 8'h0; init_val = 32'h0;
    test_reset();
    test_preload();
    test_directed();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
